// File: rtl/psr_window_unit_if.sv
// Bundles the control-unit side of the PSR/window unit: op strobes, ALU flags,
// WRPSR data, WIM and branch condition in; PSR, branch result and exceptions out.
interface psr_window_unit_if #(
    parameter int NWINDOWS = 8
);
    logic [2:0]          op;
    logic                icc_we;
    logic                alu_n;
    logic                alu_z;
    logic                alu_v;
    logic                alu_c;
    logic [31:0]         wr_data;
    logic [NWINDOWS-1:0] wim;
    logic [3:0]          cond;

    logic [31:0]         psr_out;
    logic [4:0]          cwp;
    logic                cond_true;
    logic                exc_valid;
    logic [5:0]          exc_tt;
    logic                error_mode;

    modport master (
        output op, icc_we, alu_n, alu_z, alu_v, alu_c, wr_data, wim, cond,
        input  psr_out, cwp, cond_true, exc_valid, exc_tt, error_mode
    );

    modport slave (
        input  op, icc_we, alu_n, alu_z, alu_v, alu_c, wr_data, wim, cond,
        output psr_out, cwp, cond_true, exc_valid, exc_tt, error_mode
    );
endinterface

// File: rtl/psr_window_unit.sv
// SPARC processor-state unit: PSR storage, icc update, Bicc evaluation and
// WIM-checked register-window sequencing for SAVE/RESTORE/TRAP/RETT/WRPSR.
//
// state      | meaning
// MODE_RUN   | normal operation, ops and icc_we are honoured
// MODE_ERROR | TRAP taken with ET=0; everything frozen until reset
module psr_window_unit #(
    parameter int NWINDOWS = 8
) (
    input logic           clk,
    input logic           rst_n,
    psr_window_unit_if.slave bus
);

    typedef enum logic {
        MODE_RUN   = 1'b0,
        MODE_ERROR = 1'b1
    } mode_t;

    localparam logic [2:0] OP_SAVE    = 3'd1;
    localparam logic [2:0] OP_RESTORE = 3'd2;
    localparam logic [2:0] OP_TRAP    = 3'd3;
    localparam logic [2:0] OP_RETT    = 3'd4;
    localparam logic [2:0] OP_WRPSR   = 3'd5;

    localparam logic [5:0] TT_ILLEGAL = 6'h02;
    localparam logic [5:0] TT_PRIV    = 6'h03;
    localparam logic [5:0] TT_WOF     = 6'h05;
    localparam logic [5:0] TT_WUF     = 6'h06;

    localparam logic [4:0]          CWP_MAX = 5'(NWINDOWS - 1);
    localparam logic [5:0]          NWIN_W  = 6'(NWINDOWS);
    localparam logic [NWINDOWS-1:0] WIM_ONE = {{(NWINDOWS-1){1'b0}}, 1'b1};

    mode_t       mode_q, mode_d;
    logic [3:0]  icc_q, icc_d;
    logic [3:0]  pil_q, pil_d;
    logic        s_q, s_d;
    logic        ps_q, ps_d;
    logic        et_q, et_d;
    logic [4:0]  cwp_q, cwp_d;
    logic        exc_valid_q, exc_valid_d;
    logic [5:0]  exc_tt_q, exc_tt_d;

    logic [4:0]  cwp_dec;
    logic [4:0]  cwp_inc;
    logic        wim_dec;
    logic        wim_inc;
    logic        wr_cwp_bad;
    logic        unused_wr;

    // Window neighbours with explicit wrap so non-power-of-two NWINDOWS works.
    assign cwp_dec    = (cwp_q == 5'd0)    ? CWP_MAX : cwp_q - 5'd1;
    assign cwp_inc    = (cwp_q == CWP_MAX) ? 5'd0    : cwp_q + 5'd1;
    assign wim_dec    = |(bus.wim & (WIM_ONE << cwp_dec));
    assign wim_inc    = |(bus.wim & (WIM_ONE << cwp_inc));
    assign wr_cwp_bad = {1'b0, bus.wr_data[4:0]} >= NWIN_W;
    assign unused_wr  = ^{bus.wr_data[31:24], bus.wr_data[19:12]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q      <= MODE_RUN;
            icc_q       <= 4'd0;
            pil_q       <= 4'd0;
            s_q         <= 1'b1;
            ps_q        <= 1'b0;
            et_q        <= 1'b0;
            cwp_q       <= 5'd0;
            exc_valid_q <= 1'b0;
            exc_tt_q    <= 6'd0;
        end else begin
            mode_q      <= mode_d;
            icc_q       <= icc_d;
            pil_q       <= pil_d;
            s_q         <= s_d;
            ps_q        <= ps_d;
            et_q        <= et_d;
            cwp_q       <= cwp_d;
            exc_valid_q <= exc_valid_d;
            exc_tt_q    <= exc_tt_d;
        end
    end

    always_comb begin
        mode_d      = mode_q;
        icc_d       = icc_q;
        pil_d       = pil_q;
        s_d         = s_q;
        ps_d        = ps_q;
        et_d        = et_q;
        cwp_d       = cwp_q;
        exc_valid_d = 1'b0;
        exc_tt_d    = exc_tt_q;

        if (mode_q == MODE_RUN) begin
            // Flag load rides along with every op; a successful WRPSR overrides it below.
            if (bus.icc_we) begin
                icc_d = {bus.alu_n, bus.alu_z, bus.alu_v, bus.alu_c};
            end

            case (bus.op)
                OP_SAVE: begin
                    if (wim_dec) begin
                        exc_valid_d = 1'b1;
                        exc_tt_d    = TT_WOF;
                    end else begin
                        cwp_d = cwp_dec;
                    end
                end
                OP_RESTORE: begin
                    if (wim_inc) begin
                        exc_valid_d = 1'b1;
                        exc_tt_d    = TT_WUF;
                    end else begin
                        cwp_d = cwp_inc;
                    end
                end
                OP_TRAP: begin
                    if (!et_q) begin
                        mode_d = MODE_ERROR;
                    end else begin
                        ps_d  = s_q;
                        s_d   = 1'b1;
                        et_d  = 1'b0;
                        cwp_d = cwp_dec;
                    end
                end
                OP_RETT: begin
                    if (et_q) begin
                        exc_valid_d = 1'b1;
                        exc_tt_d    = TT_ILLEGAL;
                    end else if (!s_q) begin
                        exc_valid_d = 1'b1;
                        exc_tt_d    = TT_PRIV;
                    end else if (wim_inc) begin
                        exc_valid_d = 1'b1;
                        exc_tt_d    = TT_WUF;
                    end else begin
                        et_d  = 1'b1;
                        s_d   = ps_q;
                        cwp_d = cwp_inc;
                    end
                end
                OP_WRPSR: begin
                    if (!s_q) begin
                        exc_valid_d = 1'b1;
                        exc_tt_d    = TT_PRIV;
                    end else if (wr_cwp_bad) begin
                        exc_valid_d = 1'b1;
                        exc_tt_d    = TT_ILLEGAL;
                    end else begin
                        icc_d = bus.wr_data[23:20];
                        pil_d = bus.wr_data[11:8];
                        s_d   = bus.wr_data[7];
                        ps_d  = bus.wr_data[6];
                        et_d  = bus.wr_data[5];
                        cwp_d = bus.wr_data[4:0];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        logic n, z, v, c;
        {n, z, v, c} = icc_q;
        bus.cond_true = 1'b0;
        case (bus.cond)
            4'h0: bus.cond_true = 1'b0;
            4'h1: bus.cond_true = z;
            4'h2: bus.cond_true = z | (n ^ v);
            4'h3: bus.cond_true = n ^ v;
            4'h4: bus.cond_true = c | z;
            4'h5: bus.cond_true = c;
            4'h6: bus.cond_true = n;
            4'h7: bus.cond_true = v;
            4'h8: bus.cond_true = 1'b1;
            4'h9: bus.cond_true = ~z;
            4'hA: bus.cond_true = ~(z | (n ^ v));
            4'hB: bus.cond_true = ~(n ^ v);
            4'hC: bus.cond_true = ~(c | z);
            4'hD: bus.cond_true = ~c;
            4'hE: bus.cond_true = ~n;
            4'hF: bus.cond_true = ~v;
            default: bus.cond_true = 1'b0;
        endcase
    end

    assign bus.psr_out    = {8'h00, icc_q, 8'h00, pil_q, s_q, ps_q, et_q, cwp_q};
    assign bus.cwp        = cwp_q;
    assign bus.exc_valid  = exc_valid_q;
    assign bus.exc_tt     = exc_tt_q;
    assign bus.error_mode = (mode_q == MODE_ERROR);

endmodule

// File: tb/tb_psr_window_unit.sv
// Directed plus randomized bench for psr_window_unit against an arithmetic PSR model.
module tb_psr_window_unit;

    localparam int NW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    psr_window_unit_if #(.NWINDOWS(NW)) bus ();

    psr_window_unit #(.NWINDOWS(NW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    logic [3:0] m_icc;
    logic [3:0] m_pil;
    logic       m_s, m_ps, m_et;
    int         m_cwp;
    logic       m_err;
    logic       m_exc;
    logic [5:0] m_tt;

    function automatic logic [31:0] m_psr();
        return {8'h00, m_icc, 8'h00, m_pil, m_s, m_ps, m_et, 5'(m_cwp)};
    endfunction

    // Upper half of the Bicc table is the negation of the lower half.
    function automatic logic cond_model(input logic [3:0] cc, input logic [3:0] icc);
        logic n, z, v, c, base;
        {n, z, v, c} = icc;
        case (cc[2:0])
            3'd0: base = 1'b0;
            3'd1: base = z;
            3'd2: base = z | (n ^ v);
            3'd3: base = n ^ v;
            3'd4: base = c | z;
            3'd5: base = c;
            3'd6: base = n;
            default: base = v;
        endcase
        return cc[3] ? ~base : base;
    endfunction

    task automatic model_reset();
        m_icc = 4'd0; m_pil = 4'd0; m_s = 1'b1; m_ps = 1'b0; m_et = 1'b0;
        m_cwp = 0; m_err = 1'b0; m_exc = 1'b0; m_tt = 6'd0;
    endtask

    task automatic raise(input logic [5:0] tt);
        m_exc = 1'b1;
        m_tt  = tt;
    endtask

    task automatic model_step(input logic [2:0] op, input logic we, input logic [3:0] nzvc,
                              input logic [31:0] wr, input logic [NW-1:0] wim);
        logic [3:0] new_icc;
        int down, up;
        m_exc = 1'b0;
        if (m_err) return;
        new_icc = we ? nzvc : m_icc;
        down = (m_cwp + NW - 1) % NW;
        up   = (m_cwp + 1) % NW;
        case (op)
            3'd1: if (wim[down]) raise(6'h05); else m_cwp = down;
            3'd2: if (wim[up]) raise(6'h06); else m_cwp = up;
            3'd3: begin
                if (!m_et) m_err = 1'b1;
                else begin m_ps = m_s; m_s = 1'b1; m_et = 1'b0; m_cwp = down; end
            end
            3'd4: begin
                if (m_et) raise(6'h02);
                else if (!m_s) raise(6'h03);
                else if (wim[up]) raise(6'h06);
                else begin m_et = 1'b1; m_s = m_ps; m_cwp = up; end
            end
            3'd5: begin
                if (!m_s) raise(6'h03);
                else if (int'(wr[4:0]) >= NW) raise(6'h02);
                else begin
                    new_icc = wr[23:20]; m_pil = wr[11:8];
                    m_s = wr[7]; m_ps = wr[6]; m_et = wr[5]; m_cwp = int'(wr[4:0]);
                end
            end
            default: ;
        endcase
        m_icc = new_icc;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag);
        chk({tag, ".psr"}, bus.psr_out, m_psr());
        chk({tag, ".cwp"}, 32'(bus.cwp), 32'(m_cwp));
        chk({tag, ".exc_valid"}, 32'(bus.exc_valid), 32'(m_exc));
        chk({tag, ".exc_tt"}, 32'(bus.exc_tt), 32'(m_tt));
        chk({tag, ".error_mode"}, 32'(bus.error_mode), 32'(m_err));
    endtask

    task automatic do_op(input string tag, input logic [2:0] op, input logic we,
                         input logic [3:0] nzvc, input logic [31:0] wr,
                         input logic [NW-1:0] wim, input logic [3:0] cc);
        @(negedge clk);
        bus.op = op; bus.icc_we = we;
        {bus.alu_n, bus.alu_z, bus.alu_v, bus.alu_c} = nzvc;
        bus.wr_data = wr; bus.wim = wim; bus.cond = cc;
        #1;
        chk({tag, ".cond_true"}, 32'(bus.cond_true), 32'(cond_model(cc, m_icc)));
        @(posedge clk);
        model_step(op, we, nzvc, wr, wim);
        #1;
        chk_state(tag);
    endtask

    task automatic idle_inputs();
        bus.op = 3'd0; bus.icc_we = 1'b0;
        {bus.alu_n, bus.alu_z, bus.alu_v, bus.alu_c} = 4'd0;
        bus.wr_data = 32'd0; bus.wim = '0; bus.cond = 4'd0;
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        #1;
        chk_state(tag);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [2:0]    r_op;
        logic [31:0]   r_wr;
        logic [NW-1:0] r_wim;

        idle_inputs();
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset.psr", bus.psr_out, 32'h0000_0080);
        rst_n = 1'b1;

        do_op("nop", 3'd0, 1'b0, 4'h0, 32'd0, '0, 4'h8);
        chk("nop.psr_const", bus.psr_out, 32'h0000_0080);

        do_op("icc_load", 3'd0, 1'b1, 4'b1010, 32'd0, '0, 4'h0);
        chk("icc_load.nzvc", 32'(bus.psr_out[23:20]), 32'hA);
        do_op("cond_l", 3'd0, 1'b0, 4'h0, 32'd0, '0, 4'h3);
        do_op("cond_le", 3'd0, 1'b0, 4'h0, 32'd0, '0, 4'h2);
        do_op("cond_ge", 3'd0, 1'b0, 4'h0, 32'd0, '0, 4'hB);

        do_op("save_wof", 3'd1, 1'b0, 4'h0, 32'd0, 8'h80, 4'h0);
        chk("save_wof.tt_const", 32'(bus.exc_tt), 32'h05);
        do_op("after_wof", 3'd0, 1'b0, 4'h0, 32'd0, '0, 4'h0);
        do_op("save_wrap", 3'd1, 1'b0, 4'h0, 32'd0, 8'h01, 4'h0);
        chk("save_wrap.cwp_const", 32'(bus.cwp), 32'd7);
        do_op("restore_wrap", 3'd2, 1'b0, 4'h0, 32'd0, 8'h00, 4'h0);
        do_op("restore_wuf", 3'd1, 1'b0, 4'h0, 32'd0, 8'h00, 4'h0);
        do_op("restore_wuf2", 3'd2, 1'b0, 4'h0, 32'd0, 8'h01, 4'h0);

        do_reset("rst1");
        do_op("wr_user_et", 3'd5, 1'b0, 4'h0, 32'h0000_0023, '0, 4'h0);
        do_op("trap_ok", 3'd3, 1'b0, 4'h0, 32'd0, '0, 4'h0);
        chk("trap_ok.psr_const", bus.psr_out, 32'h0000_0082);
        do_op("trap_err", 3'd3, 1'b0, 4'h0, 32'd0, '0, 4'h0);
        do_op("err_save", 3'd1, 1'b1, 4'hF, 32'd0, '0, 4'h0);
        do_op("err_wrpsr", 3'd5, 1'b1, 4'h5, 32'h00A0_0AE5, '0, 4'h1);
        chk("err.mode_const", 32'(bus.error_mode), 32'd1);

        do_reset("rst2");
        do_op("wrpsr_sup", 3'd5, 1'b1, 4'h3, 32'h00A0_0AE5, '0, 4'h0);
        chk("wrpsr_sup.psr_const", bus.psr_out, 32'h00A0_0AE5);
        do_op("rett_et", 3'd4, 1'b0, 4'h0, 32'd0, '0, 4'h0);
        do_op("wrpsr_badcwp", 3'd5, 1'b0, 4'h0, 32'h00A0_0AE9, '0, 4'h0);
        chk("wrpsr_badcwp.psr_const", bus.psr_out, 32'h00A0_0AE5);

        // Async reset between edges while a faulting SAVE is on the bus.
        do_op("pre_save", 3'd1, 1'b0, 4'h0, 32'd0, '0, 4'h0);
        @(negedge clk);
        bus.op = 3'd1; bus.wim = '1;
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk_state("async_rst");
        @(posedge clk);
        #1;
        chk_state("async_rst_edge");
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;

        for (int i = 0; i < 400; i++) begin
            if (m_err && ($urandom_range(0, 2) == 0)) do_reset("rnd_rst");
            r_op = 3'($urandom_range(0, 7));
            if (r_op == 3'd3 && $urandom_range(0, 3) != 0) r_op = 3'd5;
            r_wr = $urandom;
            r_wr[4:0] = 5'($urandom_range(0, NW + 1));
            if ($urandom_range(0, 3) != 0) r_wr[7] = 1'b1;
            r_wim = NW'($urandom & $urandom);
            do_op("rnd", r_op, 1'($urandom), 4'($urandom), r_wr, r_wim, 4'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
